// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters drive decode stall/issue, plus sticky deadlock and writeback-error flags.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear a source hazard.
module reg_scoreboard #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_wen,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        stall,
  output logic        issue,
  output logic [31:0] busy_vec,
  output logic        deadlock,
  output logic        wb_err
);

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  logic [1:0]  cnt_q   [31:1];
  logic [1:0]  cnt_eff [32];
  logic [15:0] run_q;
  logic        haz1, haz2, waw;
  logic        inc_en, dec_en, wb_bad;

  // While reset is asserted the counters read as zero so decode sees no hazards.
  always_comb begin
    cnt_eff[0] = 2'd0;
    for (int r = 1; r < 32; r++) begin
      cnt_eff[r] = rst ? cnt_q[r] : 2'd0;
    end
  end

  always_comb begin
    haz1 = id_rs1_used && (id_rs1 != 5'd0) && (cnt_eff[id_rs1] != 2'd0);
    haz2 = id_rs2_used && (id_rs2 != 5'd0) && (cnt_eff[id_rs2] != 2'd0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_valid && (wb_rd == id_rs1) && (cnt_eff[id_rs1] == 2'd1)) haz1 = 1'b0;
    if (wb_valid && (wb_rd == id_rs2) && (cnt_eff[id_rs2] == 2'd1)) haz2 = 1'b0;
`endif
    waw    = id_rd_wen && (id_rd != 5'd0) && (cnt_eff[id_rd] == 2'd3);
    stall  = id_valid && !flush && (haz1 || haz2 || waw);
    issue  = id_valid && !flush && !stall;
    inc_en = issue && id_rd_wen && (id_rd != 5'd0);
    dec_en = wb_valid && (wb_rd != 5'd0) && (cnt_eff[wb_rd] != 2'd0);
    wb_bad = wb_valid && (wb_rd != 5'd0) && (cnt_eff[wb_rd] == 2'd0);
  end

  // An issue and a retire on the same register cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= 2'd0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_en && (id_rd == 5'(r)) && !(dec_en && (wb_rd == 5'(r))))
          cnt_q[r] <= cnt_q[r] + 2'd1;
        else if (dec_en && (wb_rd == 5'(r)) && !(inc_en && (id_rd == 5'(r))))
          cnt_q[r] <= cnt_q[r] - 2'd1;
      end
    end
  end

  always_comb begin
    busy_vec[0] = 1'b0;
    for (int r = 1; r < 32; r++) busy_vec[r] = (cnt_q[r] != 2'd0);
  end

  // Stall-run counter saturates at the timeout; both error flags stay set until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q    <= 16'd0;
      deadlock <= 1'b0;
      wb_err   <= 1'b0;
    end else begin
      if (stall) begin
        if (run_q != TMO) run_q <= run_q + 16'd1;
        if (run_q == TMO - 16'd1) deadlock <= 1'b1;
      end else begin
        run_q <= 16'd0;
      end
      if (wb_bad) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with a per-cycle reference model and literal spot checks.
module tb_reg_scoreboard;
  localparam int T = 4;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst, id_valid, id_rs1_used, id_rs2_used, id_rd_wen, flush, wb_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic stall, issue, deadlock, wb_err;
  logic [31:0] busy_vec;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  int cnt_m [32];
  int run_m = 0;
  bit dl_m = 0, err_m = 0;

  reg_scoreboard #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_wen(id_rd_wen), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .issue(issue), .busy_vec(busy_vec), .deadlock(deadlock), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending writes per register; reset makes every count read as zero.
  function automatic bit src_haz(input bit used, input logic [4:0] rs);
    if (!used || rs == 5'd0 || !rst) return 1'b0;
    if (cnt_m[rs] == 0) return 1'b0;
    if (BYP && wb_valid && wb_rd == rs && cnt_m[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    bit w;
    w = rst && id_rd_wen && id_rd != 5'd0 && cnt_m[id_rd] == 3;
    return id_valid && !flush && (src_haz(id_rs1_used, id_rs1) || src_haz(id_rs2_used, id_rs2) || w);
  endfunction

  function automatic bit exp_issue();
    return id_valid && !flush && !exp_stall();
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (cnt_m[r] > 0);
    return b;
  endfunction

  always @(posedge clk) begin
    bit st, inc, dec;
    if (!rst) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      run_m = 0; dl_m = 0; err_m = 0;
    end else begin
      st  = exp_stall();
      inc = exp_issue() && id_rd_wen && id_rd != 5'd0;
      dec = wb_valid && wb_rd != 5'd0 && cnt_m[wb_rd] > 0;
      if (wb_valid && wb_rd != 5'd0 && cnt_m[wb_rd] == 0) err_m = 1;
      if (!(inc && dec && id_rd == wb_rd)) begin
        if (inc) cnt_m[id_rd] = cnt_m[id_rd] + 1;
        if (dec) cnt_m[wb_rd] = cnt_m[wb_rd] - 1;
      end
      if (st) begin
        run_m = (run_m + 1 > T) ? T : run_m + 1;
        if (run_m == T) dl_m = 1;
      end else run_m = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", 32'(stall), 32'(exp_stall()));
      chk("m_issue", 32'(issue), 32'(exp_issue()));
      chk("m_busy", busy_vec, exp_busy());
      chk("m_deadlock", 32'(deadlock), 32'(dl_m));
      chk("m_wb_err", 32'(wb_err), 32'(err_m));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_wen = 0; flush = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic wr(input logic [4:0] rd);
    id_valid = 1; id_rd = rd; id_rd_wen = 1;
  endtask

  task automatic rd1(input logic [4:0] rs);
    id_valid = 1; id_rs1 = rs; id_rs1_used = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    nxt(); nxt();
    chk_en = 1;
    #1;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_deadlock", 32'(deadlock), 32'h0);
    chk("rst_wb_err", 32'(wb_err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    rst = 1;

    // RAW hazard on x5 held until its writeback
    nxt(); wr(5'd5); #1 chk("raw_issue_rd5", 32'(issue), 32'h1);
    nxt(); idle(); #1 chk("raw_busy5", 32'(busy_vec[5]), 32'h1);
    nxt(); nxt();
    nxt(); rd1(5'd5); #1 chk("raw_stall0", 32'(stall), 32'h1);
    nxt(); #1 chk("raw_stall1", 32'(stall), 32'h1);
    nxt(); wb_valid = 1; wb_rd = 5'd5;
    #1 chk("raw_wb_stall", 32'(stall), BYP ? 32'h0 : 32'h1);
    chk("raw_wb_issue", 32'(issue), BYP ? 32'h1 : 32'h0);
    nxt(); wb_valid = 0; #1 chk("raw_after_issue", 32'(issue), 32'h1);
    chk("raw_busy5_clear", 32'(busy_vec[5]), 32'h0);

    // Counter saturation on x7 blocks a fourth write
    nxt(); idle(); wr(5'd7);
    nxt(); nxt();
    nxt(); #1 chk("waw_stall", 32'(stall), 32'h1);
    chk("waw_no_issue", 32'(issue), 32'h0);
    nxt(); wb_valid = 1; wb_rd = 5'd7; #1 chk("waw_stall_wb", 32'(stall), 32'h1);
    nxt(); wb_valid = 0; #1 chk("waw_issue_after_wb", 32'(issue), 32'h1);
    nxt(); idle(); wb_valid = 1; wb_rd = 5'd7;
    nxt(); nxt();
    nxt(); wb_valid = 0; #1 chk("waw_drained", 32'(busy_vec[7]), 32'h0);

    // Simultaneous issue and retire on x9
    nxt(); wr(5'd9);
    nxt(); wb_valid = 1; wb_rd = 5'd9;
    nxt(); idle(); #1 chk("same_cycle_busy9", 32'(busy_vec[9]), 32'h1);
    wb_valid = 1; wb_rd = 5'd9;
    nxt(); idle(); #1 chk("x9_retired", 32'(busy_vec[9]), 32'h0);

    // Writeback error flag
    nxt(); wb_valid = 1; wb_rd = 5'd0;
    nxt(); idle(); #1 chk("wb_x0_no_err", 32'(wb_err), 32'h0);
    wb_valid = 1; wb_rd = 5'd12;
    nxt(); idle(); #1 chk("wb_err_set", 32'(wb_err), 32'h1);
    chk("wb_err_no_busy12", 32'(busy_vec[12]), 32'h0);
    nxt(); nxt(); #1 chk("wb_err_held", 32'(wb_err), 32'h1);

    // Deadlock after T stalled edges, then flush dominance
    nxt(); wr(5'd3);
    nxt(); idle(); rd1(5'd3); #1 chk("dl_stall", 32'(stall), 32'h1);
    nxt(); nxt(); nxt(); #1 chk("dl_not_yet", 32'(deadlock), 32'h0);
    nxt(); #1 chk("dl_set", 32'(deadlock), 32'h1);
    flush = 1; id_rd = 5'd4; id_rd_wen = 1;
    #1 chk("flush_stall", 32'(stall), 32'h0);
    chk("flush_issue", 32'(issue), 32'h0);
    nxt(); #1 chk("flush_no_inc", busy_vec & 32'h18, 32'h8);
    chk("dl_sticky", 32'(deadlock), 32'h1);

    // Reset forces hazard-free decode and clears all state
    nxt(); idle(); rst = 0; rd1(5'd3);
    #1 chk("rst_hold_busy3", 32'(busy_vec[3]), 32'h1);
    chk("rst_comb_stall", 32'(stall), 32'h0);
    chk("rst_comb_issue", 32'(issue), 32'h1);
    nxt(); #1 chk("rst2_busy", busy_vec, 32'h0);
    chk("rst2_deadlock", 32'(deadlock), 32'h0);
    chk("rst2_wb_err", 32'(wb_err), 32'h0);
    rst = 1; idle();
    nxt(); nxt();
    @(posedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, consecutive stall cycles before deadlock is flagged (range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port id_valid  input  1  decode stage holds a valid instruction.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  source register indices (instr[19:15], instr[24:20]).
REQ-006 SHALL have ports id_rs1_used, id_rs2_used  input  1 each  instruction actually reads that source.
REQ-007 SHALL have ports id_rd  input  5 and id_rd_wen  input  1  destination index (instr[11:7]) and write intent.
REQ-008 SHALL have port flush  input  1  squash the decode-stage instruction this cycle.
REQ-009 SHALL have ports wb_valid  input  1 and wb_rd  input  5  register-file write retiring this cycle (same signals as reg_file write port).
REQ-010 SHALL have port stall  output  1  hold IF/ID and inject bubble into ID/EXE.
REQ-011 SHALL have port issue  output  1  instruction leaves decode this cycle.
REQ-012 SHALL have port busy_vec  output  32  bit r = register r has >=1 pending write.
REQ-013 SHALL have ports deadlock  output  1 and wb_err  output  1  sticky error flags.

Function
REQ-014 SHALL keep a 2-bit pending counter cnt[r] per register r=1..31; cnt[0] SHALL be constant 0.
REQ-015 SHALL compute haz1 = id_rs1_used & id_rs1!=0 & cnt[id_rs1]!=0; haz2 likewise for rs2.
REQ-016 SHALL compute waw = id_rd_wen & id_rd!=0 & cnt[id_rd]==3 (counter saturation guard).
REQ-017 SHALL drive stall = id_valid & ~flush & (haz1|haz2|waw), combinationally, zero cycle latency.
REQ-018 SHALL drive issue = id_valid & ~flush & ~stall, combinationally.
REQ-019 SHALL increment cnt[id_rd] on a clock edge where issue & id_rd_wen & id_rd!=0.
REQ-020 SHALL decrement cnt[wb_rd] on a clock edge where wb_valid & wb_rd!=0 & cnt[wb_rd]!=0.
REQ-021 SHALL leave cnt unchanged when increment and decrement target the same register in the same cycle.
REQ-022 SHALL ignore wb_valid with cnt[wb_rd]==0 (wb_rd!=0) and set wb_err to 1 on that edge.
REQ-023 SHALL ignore wb_rd==0 and id_rd==0 for all counting and hazard purposes.
REQ-024 SHALL drive busy_vec[r] = (cnt[r]!=0) from registered state; new pending visible the cycle after issue.
REQ-025 SHALL keep a 16-bit stall-run counter: increment while stall=1, clear to 0 on any cycle stall=0.
REQ-026 SHALL set deadlock to 1 on the edge where the stall-run counter reaches TIMEOUT_CYCLES; counter SHALL saturate thereafter.
REQ-027 SHALL treat flush as dominant: no stall, no issue, no counter increment; pending writebacks continue to decrement.

Reset
REQ-028 SHALL, on a clock edge with rst=0, clear all cnt, stall-run counter, deadlock and wb_err to 0, overriding all other inputs.
REQ-029 SHALL, during reset, still drive stall/issue combinationally from inputs, with all cnt treated as 0.
REQ-030 SHALL clear deadlock and wb_err only via reset.

Configuration
REQ-031 SHALL support macro SCOREBOARD_WB_BYPASS_EN.
REQ-032 With SCOREBOARD_WB_BYPASS_EN defined: haz1/haz2 SHALL be suppressed when wb_valid & wb_rd==source & cnt[source]==1 (write-back forwarded to decode same cycle).
REQ-033 Without it: hazard SHALL persist through the writeback cycle; source readable the following cycle.

Verification
REQ-034 Issue rd=5, 3 idle cycles, then read rs1=5 -> stall=1 each cycle until wb_valid wb_rd=5; issue=1 the cycle after (same cycle if bypass enabled).
REQ-035 Issue three writes to rd=7 with no wb, then fourth write to rd=7 -> cnt[7]=3, fourth stalls (waw); one wb to 7 -> fourth issues next cycle.
REQ-036 Same cycle: issue rd=9 and wb_valid wb_rd=9 with cnt[9]=1 -> cnt[9] stays 1, busy_vec[9]=1.
REQ-037 wb_valid wb_rd=12 with cnt[12]=0 -> wb_err=1 next cycle, held until rst=0 edge; wb_rd=0 -> no error.
REQ-038 TIMEOUT_CYCLES=4, hold rs1 hazard, no wb -> deadlock=1 after 4th stalled edge; flush=1 with hazard -> stall=0, issue=0, cnt unchanged.
